// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a valid/ready handshake on both sides.
// Shifts, add/sub and logic ops complete one edge after acceptance;
// MUL/MULH/DIVU/REMU run a WIDTH-step shift-add / restoring-subtract
// sequencer. Results and flags are held until the consumer takes them.
module seq_alu #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_A,
   input  logic [WIDTH-1:0] in_B,
   input  logic [4:0]       in_func,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_overflow,
   output logic             out_zero,
   output logic             out_err
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [4:0] OP_SLL  = 5'b00000;
   localparam logic [4:0] OP_SRL  = 5'b00001;
   localparam logic [4:0] OP_SRA  = 5'b00010;
   localparam logic [4:0] OP_ROL  = 5'b00011;
   localparam logic [4:0] OP_ROR  = 5'b00100;
   localparam logic [4:0] OP_MUL  = 5'b10000;
   localparam logic [4:0] OP_ADD  = 5'b10110;
   localparam logic [4:0] OP_SUB  = 5'b10111;
   localparam logic [4:0] OP_AND  = 5'b11000;
   localparam logic [4:0] OP_OR   = 5'b11001;
   localparam logic [4:0] OP_NOR  = 5'b11010;
   localparam logic [4:0] OP_XOR  = 5'b11011;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [4:0]         func_q;
   logic [WIDTH-1:0]   hi_q, lo_q, hi_d, lo_d;
   logic [SHW-1:0]     cnt_q;
   logic               last_q;
   logic [WIDTH-1:0]   result_q;
   logic               ovf_q, zero_q, err_q;

   logic [WIDTH-1:0]   result_d;
   logic               ovf_d, err_d;
   logic               is_mc_in, is_mc_q;
   logic [SHW-1:0]     shamt;
   logic [SHW:0]       rshamt;
   logic [WIDTH-1:0]   add_res, sub_res;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;

   // MUL, MULH, DIVU and REMU share the 100xx opcode group
   assign is_mc_in = (in_func[4:2] == 3'b100);
   assign is_mc_q  = (func_q[4:2]  == 3'b100);

   assign shamt   = b_q[SHW-1:0];
   // Complementary shift for rotates; s=0 yields WIDTH, which shifts everything out
   assign rshamt  = (SHW+1)'(WIDTH) - {1'b0, shamt};
   assign add_res = a_q + b_q;
   assign sub_res = a_q - b_q;

   // One iteration step: {hi,lo} is the product (MUL) or {remainder,quotient} (DIV)
   assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
   assign div_shift = {hi_q, lo_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, b_q};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      // NOTE: every variable gets a default first so no path through the block infers a latch.
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = BUSY;
         BUSY:    if (last_q)    state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   // Next iteration value of the shift-add / restoring-divide accumulators
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (func_q[1]) begin
         if (!div_diff[WIDTH]) begin
            hi_d = div_diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_d = div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_d = mul_sum[WIDTH:1];
         lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   // Result and flags for the latched operation
   always_comb begin
      result_d = '0;
      ovf_d    = 1'b0;
      err_d    = 1'b0;
      if (is_mc_q) begin
         // MUL/DIVU take the low word, MULH/REMU the high word
         result_d = func_q[0] ? hi_q : lo_q;
         ovf_d    = (func_q == OP_MUL) && (|hi_q);
         err_d    = func_q[1] && (b_q == '0);
      end else begin
         case (func_q)
            OP_SLL: result_d = a_q << shamt;
            OP_SRL: result_d = a_q >> shamt;
            OP_SRA: result_d = $signed(a_q) >>> shamt;
            OP_ROL: result_d = (a_q << shamt) | (a_q >> rshamt);
            OP_ROR: result_d = (a_q >> shamt) | (a_q << rshamt);
            OP_ADD: begin
               result_d = add_res;
               ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
               result_d = sub_res;
               ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: result_d = a_q & b_q;
            OP_OR:  result_d = a_q | b_q;
            OP_NOR: result_d = ~(a_q | b_q);
            OP_XOR: result_d = a_q ^ b_q;
            default: err_d   = 1'b1;
         endcase
      end
   end

   // Operand latch and iteration sequencer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         func_q <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         cnt_q  <= '0;
         last_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               a_q    <= in_A;
               b_q    <= in_B;
               func_q <= in_func;
               hi_q   <= '0;
               lo_q   <= in_A;
               cnt_q  <= SHW'(WIDTH - 1);
               // Single-cycle ops skip iteration and finish on the next edge
               last_q <= ~is_mc_in;
            end
            BUSY: if (!last_q) begin
               hi_q   <= hi_d;
               lo_q   <= lo_d;
               cnt_q  <= cnt_q - SHW'(1);
               last_q <= (cnt_q == '0);
            end
            default: ;
         endcase
      end
   end

   // Result registers, loaded only on entry to DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
      end else if (state_q == BUSY && last_q) begin
         result_q <= result_d;
         ovf_q    <= ovf_d;
         zero_q   <= ~|result_d;
         err_q    <= err_d;
      end
   end

   assign out_result   = result_q;
   assign out_overflow = ovf_q;
   assign out_zero     = zero_q;
   assign out_err      = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32).
module tb_seq_alu;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_A = '0;
   logic [W-1:0]  in_B = '0;
   logic [4:0]    in_func = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_result;
   logic          out_overflow;
   logic          out_zero;
   logic          out_err;

   int tests = 0;
   int fails = 0;

   seq_alu #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_A         (in_A),
      .in_B         (in_B),
      .in_func      (in_func),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_overflow (out_overflow),
      .out_zero     (out_zero),
      .out_err      (out_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one op, measure edges from accept to out_valid, check outputs, then retire it
   task automatic run_op(input string tag, input logic [4:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_res,
                         input logic exp_ovf, input logic exp_err, input int exp_lat);
      int lat;
      chk($sformatf("%s in_ready", tag), W'(in_ready), W'(1));
      in_func  = f;
      in_A     = a;
      in_B     = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         step();
         lat++;
      end
      chk($sformatf("%s latency", tag), W'(lat), W'(exp_lat));
      chk($sformatf("%s result", tag), out_result, exp_res);
      chk($sformatf("%s ovf", tag), W'(out_overflow), W'(exp_ovf));
      chk($sformatf("%s zero", tag), W'(out_zero), W'(exp_res == '0));
      chk($sformatf("%s err", tag), W'(out_err), W'(exp_err));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      int seen;

      // Reset state
      step();
      step();
      chk("rst in_ready", W'(in_ready), W'(1));
      chk("rst out_valid", W'(out_valid), W'(0));
      chk("rst result", out_result, '0);
      chk("rst flags", W'({out_overflow, out_zero, out_err}), W'(0));
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Reset in the middle of MUL 7*6 aborts without emitting a result
      in_func  = 5'b10000;
      in_A     = 32'd7;
      in_B     = 32'd6;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (5) step();
      #2 rst_n = 1'b0;
      #1;
      chk("abort in_ready", W'(in_ready), W'(1));
      chk("abort out_valid", W'(out_valid), W'(0));
      chk("abort result", out_result, '0);
      chk("abort flags", W'({out_overflow, out_zero, out_err}), W'(0));
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         step();
         if (out_valid) seen++;
      end
      chk("abort no result", W'(seen), W'(0));

      // Arithmetic and multi-cycle ops
      run_op("ADD ovf",  5'b10110, 32'h7FFF_FFFF, 32'h1,       32'h8000_0000, 1'b1, 1'b0, 1);
      run_op("SUB zero", 5'b10111, 32'd5,         32'd5,       32'h0,         1'b0, 1'b0, 1);
      run_op("MUL",      5'b10000, 32'h0001_0000, 32'h0001_0000, 32'h0,       1'b1, 1'b0, 33);
      run_op("MULH",     5'b10001, 32'h0001_0000, 32'h0001_0000, 32'h1,       1'b0, 1'b0, 33);
      run_op("DIVU",     5'b10010, 32'd100,       32'd7,       32'd14,        1'b0, 1'b0, 33);
      run_op("REMU",     5'b10011, 32'd100,       32'd7,       32'd2,         1'b0, 1'b0, 33);
      run_op("DIVU /0",  5'b10010, 32'd9,         32'd0,       32'hFFFF_FFFF, 1'b0, 1'b1, 33);
      run_op("REMU /0",  5'b10011, 32'd9,         32'd0,       32'd9,         1'b0, 1'b1, 33);

      // Shifts, rotates, logic and illegal opcode
      run_op("SRA",      5'b00010, 32'h8000_0000, 32'd4,       32'hF800_0000, 1'b0, 1'b0, 1);
      run_op("ROR",      5'b00100, 32'h1,         32'd1,       32'h8000_0000, 1'b0, 1'b0, 1);
      run_op("ROL",      5'b00011, 32'h8000_0001, 32'd4,       32'h0000_0018, 1'b0, 1'b0, 1);
      run_op("SLL s=0",  5'b00000, 32'h1234_5678, 32'd32,      32'h1234_5678, 1'b0, 1'b0, 1);
      run_op("SRL",      5'b00001, 32'hF000_0000, 32'd8,       32'h00F0_0000, 1'b0, 1'b0, 1);
      run_op("NOR",      5'b11010, 32'hF0F0_0000, 32'h0F0F_0000, 32'h0000_FFFF, 1'b0, 1'b0, 1);
      run_op("XOR",      5'b11011, 32'hFF00_FF00, 32'hFFFF_0000, 32'h00FF_FF00, 1'b0, 1'b0, 1);
      run_op("illegal",  5'b01111, 32'h1234_5678, 32'h1,       32'h0,         1'b0, 1'b1, 1);

      // Backpressure: DONE holds for 5 cycles while a new request is pending
      in_func  = 5'b10110;
      in_A     = 32'd3;
      in_B     = 32'd4;
      in_valid = 1'b1;
      step();
      in_A = 32'd1;
      in_B = 32'd2;
      step();
      chk("hold enter valid", W'(out_valid), W'(1));
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("hold%0d result", i), out_result, 32'd7);
         chk($sformatf("hold%0d valid", i), W'(out_valid), W'(1));
         chk($sformatf("hold%0d in_ready", i), W'(in_ready), W'(0));
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("release in_ready", W'(in_ready), W'(1));
      chk("release out_valid", W'(out_valid), W'(0));
      chk("release result kept", out_result, 32'd7);
      step();
      in_valid = 1'b0;
      chk("next accepted", W'(in_ready), W'(0));
      step();
      chk("next valid", W'(out_valid), W'(1));
      chk("next result", out_result, 32'd3);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the lab4 combinational ALU.
- Adds a valid/ready handshake, variable shift amount taken from operand B, iterative multi-cycle multiply/divide with high-half and remainder results, and error/overflow flags.
- Sits between the operand register file and the writeback stage in the lab datapath.
- Single-cycle ops complete in one clock; MUL/DIV run an internal sequencer.

Parameters:
- WIDTH, 32: operand and result width; must be ≥4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request.
- in_A  input  WIDTH  operand A.
- in_B  input  WIDTH  operand B; low SHW bits are the shift amount for shift ops.
- in_func  input  5  operation code.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  result.
- out_overflow  output  1  overflow flag.
- out_zero  output  1  result == 0.
- out_err  output  1  illegal opcode or divide by zero.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready=1, out_valid=0.
  - out_result=0, out_overflow=0, out_zero=0, out_err=0.
  - Iteration counter and internal accumulators cleared.
  - Reset mid-operation aborts the op; no result is emitted.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&in_ready; operands and func are latched.
  - Single-cycle op: go to DONE next edge with result registered (latency 1).
  - MUL/DIV: go to BUSY with counter=WIDTH-1.
- BUSY:
  - in_ready=0.
  - One shift-add (MUL) or restoring-subtract (DIV) step per clock.
  - Counter decrements each clock; at counter==0 the last step is done, then go to DONE.
  - out_valid rises exactly WIDTH+1 cycles after the accept edge.
  - in_valid is ignored while BUSY.
- DONE:
  - out_valid=1, in_ready=0.
  - Outputs held stable until out_ready=1, then go to IDLE on that edge.
  - A new request cannot be accepted in the same cycle; there is a one-cycle bubble.
- Outputs change only on entry to DONE; they keep their last value in IDLE/BUSY.
- Opcodes (s = in_B[SHW-1:0]):
  - 00000 SLL A<<s; 00001 SRL; 00010 SRA (sign fill); 00011 ROL; 00100 ROR.
  - s=0 returns A unchanged.
  - 10000 MUL low half of unsigned A*B.
  - 10001 MULH high half of unsigned A*B.
  - 10010 DIVU quotient; 10011 REMU remainder.
  - 10110 ADD A+B; 10111 SUB A-B (modulo 2^WIDTH).
  - 11000 AND; 11001 OR; 11010 NOR; 11011 XOR.
  - All other codes are illegal: result=0, out_err=1, latency 1, zero flag=1.
- out_overflow:
  - ADD/SUB: two's-complement signed overflow.
  - MUL: set when the high half is nonzero.
  - 0 for all other ops.
- Divide by zero (B=0):
  - DIVU result all ones; REMU result = A.
  - out_err=1.
  - Takes the full WIDTH+1 latency.
- out_zero = ~|out_result, registered together with the result.
- out_err=0 for all legal non-zero-divisor ops.

Test Plan:
- Reset during BUSY of MUL 7*6 → out_valid stays 0, in_ready=1 immediately, all outputs 0.
- ADD 0x7FFFFFFF+1 → one cycle later out_valid=1, result 0x80000000, overflow=1, zero=0; SUB 5-5 → result 0, zero=1, overflow=0.
- MUL 0x10000*0x10000 → out_valid after exactly 33 cycles, result 0, overflow=1, zero=1; MULH same operands → 0x00000001.
- DIVU 100/7 → 14; REMU → 2; DIVU 9/0 → 0xFFFFFFFF, err=1; REMU 9/0 → 9, err=1.
- SRA A=0x80000000, B=4 → 0xF8000000; ROR A=0x1, B=1 → 0x80000000; SLL with B=32 → A unchanged (s=0); func 01111 → result 0, err=1.
- Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0, in_valid ignored; out_ready=1 → IDLE next edge, new op accepted the cycle after.
